// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, instr} entries; head is always entry 0, pops shift down.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_wr_idx;

    // A push that coincides with a pop lands one slot lower because the queue shifts.
    assign w_wr_idx = i_pop ? (r_count - CW'(1)) : r_count;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (i_push && (w_wr_idx == CW'(i))) begin
                r_mem[i] <= i_push_data;
            end else if (i_pop && (i < DEPTH - 1)) begin
                r_mem[i] <= r_mem[(i < DEPTH - 1) ? i + 1 : i];
            end else begin
                r_mem[i] <= r_mem[i];
            end
        end
    end

    assign o_head  = r_mem[0];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small decode buffer.
// Optional FETCH_PERF_EN adds the fetch_bubble_cnt output and its saturating counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_bubble_cnt
`endif
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_e r_state, w_state_nxt;
    logic         r_drop, w_drop_nxt;
    logic         r_stale;
    logic [31:0]  r_req_pc;
    logic         w_grant, w_rsp_own, w_push, w_pop;
    logic [CW-1:0] w_buf_count, w_cnt_after;
    logic         w_buf_full, w_buf_empty;
    logic [63:0]  w_head;

    assign imem_req  = !rst && (r_state == REQ);
    assign imem_addr = imem_req ? pc_cur : 32'h0000_0000;
    assign w_grant   = imem_req && imem_gnt;
    // r_stale marks a response still owed to a request abandoned by reset; it is not ours.
    assign w_rsp_own = imem_rvalid && !r_stale && (r_state == WAIT);
    assign w_push    = w_rsp_own && !r_drop && !redir_valid;
    assign w_pop     = id_valid && id_ready && !redir_valid;

    assign id_valid  = !rst && !w_buf_empty;
    assign id_pc     = w_head[63:32];
    assign id_instr  = w_head[31:0];

    always_comb begin
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redir_valid) begin
            pc_next = redir_pc;
        end else if (w_grant) begin
            pc_next = pc_inc(pc_cur);
        end else begin
            pc_next = pc_cur;
        end
    end

    always_comb begin
        w_cnt_after = '0;
        if (redir_valid) begin
            w_cnt_after = '0;
        end else begin
            w_cnt_after = w_buf_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_buf_full) w_state_nxt = REQ;
                else             w_state_nxt = IDLE;
            end
            REQ: begin
                if (w_grant) w_state_nxt = WAIT;
                else         w_state_nxt = REQ;
            end
            WAIT: begin
                if (w_rsp_own) w_state_nxt = (w_cnt_after < CW'(BUF_DEPTH)) ? REQ : IDLE;
                else           w_state_nxt = WAIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_drop_nxt = r_drop;
        if (w_rsp_own) begin
            w_drop_nxt = 1'b0;
        end else begin
            w_drop_nxt = r_drop;
        end
        if (redir_valid && (((r_state == WAIT) && !w_rsp_own) || w_grant)) begin
            w_drop_nxt = 1'b1;
        end else begin
            w_drop_nxt = w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_drop   <= 1'b0;
            r_stale  <= (r_stale || (r_state == WAIT)) && !imem_rvalid;
            r_req_pc <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_drop   <= w_drop_nxt;
            r_stale  <= r_stale && !imem_rvalid;
            r_req_pc <= w_grant ? pc_cur : r_req_pc;
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_req_pc, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redir_valid),
        .o_head      (w_head),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 32'h0000_0000;
        end else if (id_ready && !id_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign fetch_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a PC register and an in-order memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    logic        gnt_en;
    int          lat;
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0040_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (mem_rvalid),
        .imem_rdata  (mem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ready    (id_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    assign imem_gnt = imem_req && gnt_en;

    always @(posedge clk) pc_cur <= pc_next;

    // In-order memory: each granted request answers lat cycles after its grant cycle.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (imem_req && imem_gnt) q.push_back('{addr: imem_addr, due: cyc_n + lat - 1});
        if (q.size() > 0 && q[0].due == cyc_n) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= instr_of(q[0].addr);
            void'(q.pop_front());
        end else begin
            mem_rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // which: 0 = request pending, 1 = grant this cycle, 2 = instruction offered to decode
    task automatic wait_for(input int which, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            hit = (which == 0) ? imem_req : (which == 1) ? (imem_req && imem_gnt) : id_valid;
            if (hit) break;
            cyc();
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        int k;
        exp_pc[0] = 32'h0040_0000;
        exp_pc[1] = 32'h0040_0004;
        exp_pc[2] = 32'h0040_0008;
        exp_pc[3] = 32'h0040_000C;

        rst = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0; id_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        repeat (3) cyc();
        #1;
        chk("rst_pc_next", pc_next, 32'h0040_0000);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);

        // Reset release, memory grants at once and answers one cycle later
        rst = 1'b0;
        #1;
        chk("c1_pc_next", pc_next, 32'h0040_0000);
        chk("c1_req", 32'(imem_req), 32'd0);
        cyc(); #1;
        chk("c2_req", 32'(imem_req), 32'd1);
        chk("c2_addr", imem_addr, 32'h0040_0000);
        chk("c2_pc_next", pc_next, 32'h0040_0004);
        cyc(); #1;
        chk("c3_no_bypass", 32'(id_valid), 32'd0);
        chk("c3_pc_next", pc_next, 32'h0040_0004);
        cyc(); #1;
        chk("c4_id_valid", 32'(id_valid), 32'd1);
        chk("c4_id_pc", id_pc, 32'h0040_0000);
        chk("c4_id_instr", id_instr, instr_of(32'h0040_0000));
        chk("c4_addr", imem_addr, 32'h0040_0004);
        chk("c4_pc_next", pc_next, 32'h0040_0008);

        // Decode stalled: two entries buffered, requests stop
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_req", 32'(imem_req), 32'd0);
            chk("full_pc_next", pc_next, 32'h0040_0008);
            chk("full_id_pc_stable", id_pc, 32'h0040_0000);
            cyc();
        end

        id_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            #1;
            if (id_valid) begin
                chk("drain_id_pc", id_pc, exp_pc[k]);
                k++;
            end
            cyc();
        end
        chk("drain_count", 32'(k), 32'd4);

        // Redirect while waiting on memory: in-flight response must be dropped
        lat = 3;
        wait_for(1, "grant_before_redir");
        cyc();
        redir_valid = 1'b1; redir_pc = 32'h0040_0100;
        #1;
        chk("redir_pc_next", pc_next, 32'h0040_0100);
        cyc();
        redir_valid = 1'b0;
        #1;
        chk("redir_flush", 32'(id_valid), 32'd0);
        wait_for(2, "redir_refill");
        chk("redir_first_pc", id_pc, 32'h0040_0100);
        chk("redir_first_instr", id_instr, instr_of(32'h0040_0100));

        // Grant withheld: address held, redirect retargets without a drop
        gnt_en = 1'b0;
        wait_for(0, "stall_req");
        redir_valid = 1'b1; redir_pc = 32'h0040_0300;
        cyc();
        redir_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_addr", imem_addr, 32'h0040_0300);
            chk("stall_pc_next", pc_next, 32'h0040_0300);
            cyc();
        end
        redir_valid = 1'b1; redir_pc = 32'h0040_0200;
        cyc();
        redir_valid = 1'b0;
        #1;
        chk("retarget_addr", imem_addr, 32'h0040_0200);
        gnt_en = 1'b1;
        wait_for(2, "retarget_fill");
        chk("retarget_id_pc", id_pc, 32'h0040_0200);
        chk("retarget_id_instr", id_instr, instr_of(32'h0040_0200));

        // PC wrap at the top of the address space
        gnt_en = 1'b0;
        wait_for(0, "wrap_req");
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        cyc();
        redir_valid = 1'b0; gnt_en = 1'b1;
        #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        wait_for(2, "wrap_fill");
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // Reset during WAIT; the abandoned response arrives after reset release
        gnt_en = 1'b0;
        wait_for(0, "late_req");
        redir_valid = 1'b1; redir_pc = 32'h0040_0040;
        cyc();
        redir_valid = 1'b0; lat = 4; gnt_en = 1'b1;
        #1;
        chk("late_grant_addr", imem_addr, 32'h0040_0040);
        cyc();
        lat = 2; rst = 1'b1;
        #1;
        chk("late_rst_pc_next", pc_next, 32'h0040_0000);
        chk("late_rst_req", 32'(imem_req), 32'd0);
        chk("late_rst_addr", imem_addr, 32'h0);
        chk("late_rst_id_valid", 32'(id_valid), 32'd0);
        cyc();
        rst = 1'b0;
        wait_for(2, "late_fill");
        chk("late_first_pc", id_pc, 32'h0040_0000);
        chk("late_first_instr", id_instr, instr_of(32'h0040_0000));
        cyc();
        wait_for(2, "late_fill2");
        chk("late_second_pc", id_pc, 32'h0040_0004);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00400000, is the fetch address driven while reset is asserted.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of entries in the fetched-instruction buffer (legal range 2..4).
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  is the reset: synchronous, active-high.
REQ-005 pc_cur  input  32  is the current PC from the PC register.
REQ-006 pc_next  output  32  is the next PC fed to the PC register, which loads it every cycle.
REQ-007 imem_req/imem_addr  output  1/32  is the instruction-memory request and its word address.
REQ-008 imem_gnt  input  1  is the request acceptance.
REQ-009 imem_rvalid/imem_rdata  input  1/32  is the response, arriving at least 1 cycle after the grant.
REQ-010 redir_valid/redir_pc  input  1/32  is the branch/jump redirect from decode/execute.
REQ-011 id_valid/id_pc/id_instr  output  1/32/32  is the fetched instruction offered to decode.
REQ-012 id_ready  input  1  is the decode acceptance; transfer occurs when id_valid && id_ready.

Function
REQ-013 FSM states SHALL be IDLE, REQ and WAIT, with at most one memory request outstanding.
REQ-014 In IDLE, when (buffer occupancy + outstanding) < BUF_DEPTH, the FSM SHALL go to REQ.
REQ-015 In REQ, imem_req=1 and imem_addr=pc_cur; on imem_gnt the FSM SHALL go to WAIT; otherwise it holds REQ with the address stable.
REQ-016 In WAIT, on imem_rvalid the FSM SHALL push {pc, rdata} into the buffer and return to REQ if credit remains, else to IDLE.
REQ-017 pc_next SHALL be computed combinationally with priority: redir_valid -> redir_pc; grant cycle -> pc_cur+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); otherwise pc_cur.
REQ-018 The buffer SHALL be FIFO ordered, with id_valid = not empty and id_pc/id_instr taken from the head entry.
REQ-019 A push becomes visible the cycle after imem_rvalid; there is no bypass path.
REQ-020 A simultaneous push and pop SHALL keep occupancy unchanged, and the credit rule guarantees no push when full.
REQ-021 On redir_valid the buffer SHALL be flushed the same edge, with id_valid=0 next cycle; a concurrent pop is discarded.
REQ-022 On redir_valid in WAIT, or in REQ with imem_gnt, a drop flag SHALL be set so that the next imem_rvalid is discarded; the flag clears on that rvalid.
REQ-023 On redir_valid in REQ without imem_gnt, the request SHALL be retargeted next cycle to the new pc_cur (no drop).
REQ-024 id_* outputs SHALL be stable while id_valid && !id_ready.

Reset
REQ-025 While rst=1: pc_next=RESET_PC, FSM=IDLE, buffer empty, drop=0, imem_req=0, id_valid=0, imem_addr=0.
REQ-026 rst asserted mid-WAIT SHALL abandon the transaction, and a late imem_rvalid arriving after rst falls SHALL be ignored (drop=1 on reset exit if a request was outstanding).

Configuration
REQ-027 With FETCH_PERF_EN defined, the block SHALL add output fetch_bubble_cnt[31:0], incremented each cycle id_ready && !id_valid, reset to 0, and saturating at 32'hFFFFFFFF.
REQ-028 Without FETCH_PERF_EN, the port and counter SHALL be absent.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/REQ/WAIT), RESET_PC_DEFAULT=32'h00400000 and PC_STEP=4.
REQ-030 The buffer SHALL be a sub-module fetch_buf (parameterised depth, push/pop/flush, full/empty/count).

Verification
REQ-031 Reset release with memory granting immediately and rvalid 1 cycle later SHALL produce pc_next sequence 00400000, 00400004, 00400008 and id_pc in that order.
REQ-032 Holding id_ready=0 with BUF_DEPTH=2 SHALL stop requests after 2 buffered instructions, with imem_req=0 and pc_next constant.
REQ-033 redir_valid with redir_pc=00400100 while in WAIT SHALL discard the in-flight response, make the first id_pc after the redirect 00400100 and keep id_valid=0 for at least 1 cycle.
REQ-034 imem_gnt held low 5 cycles SHALL keep imem_addr stable and pc_next=pc_cur, and a redirect in that window SHALL change imem_addr next cycle without a drop.
REQ-035 pc_cur=FFFFFFFC with a grant SHALL give pc_next=00000000.
REQ-036 rst pulsed during WAIT followed by a late rvalid SHALL push nothing, and the first fetch SHALL be 00400000.
